// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and helpers for the round-robin UART packet scheduler.
// Holds FSM encodings, the default header tag and the header-build function.
package uart_tx_scheduler_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ID_W    = 4;

    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_PAY_LO = 3'd3,
        S_PAY_HI = 3'd4
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [3:0] tag, input logic [ID_W-1:0] id);
        return {tag, id};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last) + k) % NUM_REQ;
            if (!any && req[IDX_W'(idx)]) begin
                any                 = 1'b1;
                grant[IDX_W'(idx)]  = 1'b1;
                grant_idx           = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one 8N1 UART transmitter between NUM_REQ requesters; each grant
// produces a header byte {tag,id} followed by the requester's payload byte.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter logic [3:0]  HDR_TAG       = HDR_TAG_DEFAULT,
    parameter int unsigned START_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           txbyte,
    output logic                 senddata,
    input  logic                 txdone,
    output logic                 busy,
    output logic [3:0]           grant_id,
    output logic                 err_timeout,
    output logic [15:0]          pkt_count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [IDX_W-1:0]   last, last_nx;
    logic [7:0]         payload, payload_nx;
    logic [NUM_REQ-1:0] ack_nx;
    logic [7:0]         txbyte_nx;
    logic               senddata_nx, busy_nx, err_nx;
    logic [3:0]         grant_id_nx;
    logic [15:0]        pkt_nx;

    logic [NUM_REQ-1:0] gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [7:0]         pay_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .last      (last),
        .grant     (gnt_onehot),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    always_comb begin
        pay_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_onehot[i]) pay_sel = req_data[i*8 +: 8];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        last_nx     = last;
        payload_nx  = payload;
        ack_nx      = '0;
        senddata_nx = 1'b0;
        txbyte_nx   = txbyte;
        busy_nx     = busy;
        grant_id_nx = grant_id;
        err_nx      = err_timeout;
        pkt_nx      = pkt_count;
        case (state)
            S_IDLE: begin
                if (txdone && gnt_any) begin
                    ack_nx      = gnt_onehot;
                    payload_nx  = pay_sel;
                    grant_id_nx = 4'(gnt_idx);
                    last_nx     = gnt_idx;
                    busy_nx     = 1'b1;
                    txbyte_nx   = hdr_byte(HDR_TAG, 4'(gnt_idx));
                    senddata_nx = 1'b1;
                    cnt_nx      = '0;
                    state_nx    = S_HDR_LO;
                end
            end
            S_HDR_LO, S_PAY_LO: begin
                // Transmitter must acknowledge the start pulse by dropping txdone
                if (!txdone) begin
                    state_nx = (state == S_HDR_LO) ? S_HDR_HI : S_PAY_HI;
                end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_HDR_HI: begin
                if (txdone) begin
                    txbyte_nx   = payload;
                    senddata_nx = 1'b1;
                    cnt_nx      = '0;
                    state_nx    = S_PAY_LO;
                end
            end
            S_PAY_HI: begin
                if (txdone) begin
                    pkt_nx   = pkt_count + 16'd1;
                    busy_nx  = 1'b0;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            last        <= IDX_W'(NUM_REQ - 1);
            payload     <= '0;
            ack         <= '0;
            senddata    <= 1'b0;
            txbyte      <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            err_timeout <= 1'b0;
            pkt_count   <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            last        <= last_nx;
            payload     <= payload_nx;
            ack         <= ack_nx;
            senddata    <= senddata_nx;
            txbyte      <= txbyte_nx;
            busy        <= busy_nx;
            grant_id    <= grant_id_nx;
            err_timeout <= err_nx;
            pkt_count   <= pkt_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and directed bench for uart_tx_scheduler against a behavioural
// packet/rotation model and a simple uart_tx_8n1 txdone model.
module tb_uart_tx_scheduler;

    localparam int unsigned N   = 4;
    localparam logic [3:0]  TAG = 4'hA;
    localparam int unsigned TMO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [7:0]     txbyte;
    logic           senddata;
    logic           txdone = 1'b1;
    logic           busy;
    logic [3:0]     grant_id;
    logic           err_timeout;
    logic [15:0]    pkt_count;

    uart_tx_scheduler #(
        .NUM_REQ       (N),
        .HDR_TAG       (TAG),
        .START_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .txbyte      (txbyte),
        .senddata    (senddata),
        .txdone      (txdone),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout),
        .pkt_count   (pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: first asserted request after 'last' in rotation order
    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx = (last + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Model state owned by the monitor process
    int             last_ref = N - 1;
    logic [7:0]     exp_pay  = 8'h00;
    bit             pend     = 1'b0;
    logic [15:0]    pkt_ref  = 16'h0000;
    logic [N-1:0]   prev_req = '0;
    logic [8*N-1:0] prev_data = '0;
    logic           prev_send = 1'b0;
    logic [7:0]     tx_log[$];
    int             ack_cnt[N] = '{default: 0};
    int             u_wait = 0;
    int             u_low  = 0;

    // Stimulus knobs owned by the main initial block
    bit          rand_uart = 1'b0;
    bit          uart_mode = 1'b0;
    int          fix_dly   = 2;
    int          fix_len   = 10;
    logic [15:0] pkt_ofs   = 16'h0000;

    // Monitor, protocol checks and uart_tx_8n1 txdone model
    always @(negedge clk) begin
        int exp_id;
        chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        chk("send_gap", 32'(senddata && prev_send), 32'd0);
        chk("ack_without_send", 32'((ack != '0) && !senddata), 32'd0);
        if (senddata && ack != '0) begin
            exp_id = rr_pick(prev_req, last_ref);
            if (exp_id < 0) begin
                chk("spurious_grant", 32'(ack), 32'd0);
            end else begin
                chk("hdr_ack", 32'(ack), 32'(1 << exp_id));
                chk("hdr_byte", 32'(txbyte), 32'({TAG, 4'(exp_id)}));
                chk("grant_id", 32'(grant_id), 32'(exp_id));
                chk("busy_on_grant", 32'(busy), 32'd1);
                last_ref = exp_id;
                exp_pay  = prev_data[exp_id*8 +: 8];
                ack_cnt[exp_id]++;
            end
            tx_log.push_back(txbyte);
        end else if (senddata) begin
            chk("pay_byte", 32'(txbyte), 32'(exp_pay));
            pend = 1'b1;
            tx_log.push_back(txbyte);
        end

        if (u_wait > 0) begin
            u_wait--;
            if (u_wait == 0) txdone = 1'b0;
        end else if (u_low > 0) begin
            u_low--;
            if (u_low == 0) begin
                txdone = 1'b1;
                if (pend) begin
                    pkt_ref++;
                    pend = 1'b0;
                end
            end
        end
        if (senddata && !uart_mode) begin
            u_wait = rand_uart ? int'($urandom_range(1, 3)) : fix_dly;
            u_low  = rand_uart ? int'($urandom_range(2, 12)) : fix_len;
        end

        if (rst) begin
            last_ref = N - 1;
            pend     = 1'b0;
            pkt_ref  = 16'h0000;
        end
        prev_req  = req;
        prev_data = req_data;
        prev_send = senddata;
    end

    task automatic step(input bit auto_drop);
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic wait_hdr(input int n, input bit auto_drop, input int budget);
        int seen = 0;
        int t    = 0;
        while (seen < n && t < budget) begin
            step(auto_drop);
            t++;
            if (senddata && ack != '0) seen++;
        end
        chk("hdr_wait_budget", 32'(seen), 32'(n));
    endtask

    task automatic wait_quiet(input int budget);
        int t = 0;
        while (!(req == '0 && !busy && txdone && !senddata) && t < budget) begin
            step(1'b1);
            t++;
        end
        chk("quiet_budget", 32'(req == '0 && !busy && txdone), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        pkt_ofs = 16'h0000;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_senddata", 32'(senddata), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_txbyte", 32'(txbyte), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
    endtask

    initial begin
        int base;
        int a2;
        int t;
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        @(posedge clk);
        #1;
        do_reset(3);

        // Single requester 2: header then payload, one ack pulse, one packet
        base = tx_log.size();
        a2   = ack_cnt[2];
        req_data[23:16] = 8'h5C;
        req = 4'b0100;
        wait_hdr(1, 1'b1, 50);
        wait_quiet(200);
        chk("t2_hdr", 32'(tx_log[base]), 32'h A2);
        chk("t2_pay", 32'(tx_log[base+1]), 32'h5C);
        chk("t2_log_len", 32'(tx_log.size() - base), 32'd2);
        chk("t2_ack2_pulses", 32'(ack_cnt[2] - a2), 32'd1);
        chk("t2_pkt", 32'(pkt_count), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);

        // All four held: strict rotation 0,1,2,3,0,1,2,3
        do_reset(1);
        base = tx_log.size();
        req_data = $urandom;
        req = 4'b1111;
        wait_hdr(8, 1'b0, 600);
        req = '0;
        wait_quiet(200);
        for (int k = 0; k < 8; k++) begin
            chk("t3_id", 32'(tx_log[base+2*k]), 32'({TAG, 4'(k % 4)}));
        end
        chk("t3_pkt", 32'(pkt_count), 32'd8);

        // Requester 1 arrives while 3 is served and 3 stays asserted: 3,1,3
        base = tx_log.size();
        req = 4'b1000;
        wait_hdr(1, 1'b0, 100);
        req = 4'b1010;
        wait_hdr(2, 1'b0, 300);
        req = '0;
        wait_quiet(200);
        chk("t4_id0", 32'(tx_log[base]), 32'h A3);
        chk("t4_id1", 32'(tx_log[base+2]), 32'h A1);
        chk("t4_id2", 32'(tx_log[base+4]), 32'h A3);

        // Reset while the payload frame is in flight, then priority restarts at 0
        req = 4'b1111;
        t = 0;
        while (!(senddata && ack == '0) && t < 100) begin
            step(1'b0);
            t++;
        end
        chk("t5_reach_payload", 32'(senddata && ack == '0), 32'd1);
        do_reset(3);
        wait_hdr(1, 1'b0, 100);
        chk("t5_first_grant", 32'(grant_id), 32'd0);
        req = '0;
        wait_quiet(200);
        chk("t5_pkt", 32'(pkt_count), 32'(16'(pkt_ref + pkt_ofs)));

        // Transmitter ignores the start pulse: timeout after exactly TMO cycles
        uart_mode = 1'b1;
        req = 4'b0001;
        wait_hdr(1, 1'b1, 100);
        repeat (TMO - 1) step(1'b1);
        chk("t6_err_early", 32'(err_timeout), 32'd0);
        step(1'b1);
        chk("t6_err", 32'(err_timeout), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pkt", 32'(pkt_count), 32'(16'(pkt_ref + pkt_ofs)));
        repeat (20) step(1'b1);
        chk("t6_err_sticky", 32'(err_timeout), 32'd1);
        uart_mode = 1'b0;
        do_reset(1);

        // Packet counter wrap from 16'hFFFF
        pkt_ofs = 16'hFFFF - pkt_ref;
        force dut.pkt_count = 16'hFFFF;
        step(1'b0);
        step(1'b0);
        release dut.pkt_count;
        step(1'b0);
        chk("t7_preload", 32'(pkt_count), 32'h FFFF);
        req_data[7:0] = 8'(($urandom));
        req = 4'b0001;
        wait_hdr(1, 1'b1, 100);
        wait_quiet(200);
        chk("t7_wrap_model", 32'(pkt_count), 32'(16'(pkt_ref + pkt_ofs)));
        chk("t7_wrap_zero", 32'(pkt_count), 32'd0);

        // Random arrivals, withdrawals and frame timing
        rand_uart = 1'b1;
        repeat (3000) begin
            step(1'b0);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req_data[i*8 +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        wait_quiet(3000);
        chk("t8_all_served", 32'(req), 32'd0);
        chk("t8_pkt", 32'(pkt_count), 32'(16'(pkt_ref + pkt_ofs)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
